kernel_pll_reconfig_ctrl: RTL and testbench

KERNEL_PLL_RECONFIG_CTRL -- requirements
Module: kernel_pll_reconfig_ctrl

---
 rtl/kernel_pll_pkg.sv | 38 +++
 rtl/pll_lock_monitor.sv | 50 +++++
 rtl/kernel_pll_reconfig_ctrl.sv | 142 ++++++++++++++
 tb/tb_kernel_pll_reconfig_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_pll_pkg.sv
// Shared definitions for the PLL reconfiguration controller: register map,
// counter-select field placement, FSM states and the counter word encoder.
package kernel_pll_pkg;

  localparam logic [5:0] ADDR_MODE  = 6'h00;
  localparam logic [5:0] ADDR_START = 6'h02;
  localparam logic [5:0] ADDR_N     = 6'h03;
  localparam logic [5:0] ADDR_M     = 6'h04;
  localparam logic [5:0] ADDR_C     = 6'h05;

  localparam int CSEL_LSB = 18;
  localparam int CSEL_W   = 5;

  typedef enum logic [3:0] {
    IDLE,
    WR_MODE,
    WR_N,
    WR_M,
    WR_C0,
    WR_C1,
    WR_START,
    LOCK_WAIT,
    FINISH
  } state_t;

  // Bypass only for a 1/1 divide; odd-duty flags unequal high/low counts.
  function automatic logic [31:0] counter_word(input logic [15:0] div,
                                               input logic [CSEL_W-1:0] sel);
    logic [31:0] w;
    w = 32'd0;
    w[15:0] = div;
    w[16] = (div == 16'h0101);
    w[17] = (div[15:8] != div[7:0]);
    w[CSEL_LSB +: CSEL_W] = sel;
    return w;
  endfunction

endpackage

// File: rtl/pll_lock_monitor.sv
// Saturating stable-lock and timeout counters; pulses flag the cycle a limit is hit.
module pll_lock_monitor #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic locked,
  output logic stable_pulse,
  output logic timeout_pulse
);

  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

  logic [SW-1:0] stable_cnt_reg, stable_cnt_next, stable_inc;
  logic [TW-1:0] timeout_cnt_reg, timeout_cnt_next, timeout_inc;

  assign stable_inc  = stable_cnt_reg + SW'(1);
  assign timeout_inc = timeout_cnt_reg + TW'(1);

  // Pulses fire on the cycle whose increment reaches the limit.
  assign stable_pulse  = enable && locked && (stable_inc >= S_MAX);
  assign timeout_pulse = enable && (timeout_inc >= T_MAX);

  always_comb begin
    stable_cnt_next  = '0;
    timeout_cnt_next = '0;
    if (enable) begin
      if (locked) begin
        stable_cnt_next = (stable_cnt_reg < S_MAX) ? stable_inc : stable_cnt_reg;
      end
      timeout_cnt_next = (timeout_cnt_reg < T_MAX) ? timeout_inc : timeout_cnt_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
    end else begin
      stable_cnt_reg  <= stable_cnt_next;
      timeout_cnt_reg <= timeout_cnt_next;
    end
  end

endmodule

// File: rtl/kernel_pll_reconfig_ctrl.sv
// Programs PLL M/N/C0/C1 divides through the reconfig management port,
// starts reconfiguration and waits for a stable lock or a timeout.
module kernel_pll_reconfig_ctrl
  import kernel_pll_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65535
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_m,
  input  logic [15:0] cfg_n,
  input  logic [15:0] cfg_c0,
  input  logic [15:0] cfg_c1,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_t state_reg, state_next;
  logic   error_reg;
  logic   stable_pulse, timeout_pulse;
  logic   accept;

  // Captured divides, ordered N, M, C0, C1.
  logic [3:0][15:0] div_reg;
  logic [3:0][31:0] div_word;

  assign accept = (state_reg == IDLE) && cfg_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign div_word[gi] = counter_word(div_reg[gi], (gi == 3) ? CSEL_W'(1) : CSEL_W'(0));
    end
  endgenerate

  pll_lock_monitor #(
    .STABLE_CYCLES  (LOCK_STABLE_CYCLES),
    .TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES)
  ) u_lock_monitor (
    .clk           (refclk),
    .rst           (rst),
    .enable        (state_reg == LOCK_WAIT),
    .locked        (pll_locked),
    .stable_pulse  (stable_pulse),
    .timeout_pulse (timeout_pulse)
  );

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg <= IDLE;
      error_reg <= 1'b0;
      div_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        div_reg   <= {cfg_c1, cfg_c0, cfg_m, cfg_n};
        error_reg <= 1'b0;
      end else if (state_reg == LOCK_WAIT && !stable_pulse && timeout_pulse) begin
        error_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (cfg_valid) state_next = WR_MODE;
      WR_MODE:   if (!mgmt_waitrequest) state_next = WR_N;
      WR_N:      if (!mgmt_waitrequest) state_next = WR_M;
      WR_M:      if (!mgmt_waitrequest) state_next = WR_C0;
      WR_C0:     if (!mgmt_waitrequest) state_next = WR_C1;
      WR_C1:     if (!mgmt_waitrequest) state_next = WR_START;
      WR_START:  if (!mgmt_waitrequest) state_next = LOCK_WAIT;
      // A stable lock takes precedence over a simultaneous timeout.
      LOCK_WAIT: begin
        if (stable_pulse)       state_next = FINISH;
        else if (timeout_pulse) state_next = IDLE;
      end
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs are held quiet while reset is asserted so an abort issues no write.
  always_comb begin
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    cfg_ready      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    if (!rst) begin
      cfg_ready = (state_reg == IDLE);
      busy      = (state_reg != IDLE);
      done      = (state_reg == FINISH);
      error     = error_reg;
      case (state_reg)
        WR_MODE: begin
          mgmt_write   = 1'b1;
          mgmt_address = ADDR_MODE;
        end
        WR_N: begin
          mgmt_write     = 1'b1;
          mgmt_address   = ADDR_N;
          mgmt_writedata = div_word[0];
        end
        WR_M: begin
          mgmt_write     = 1'b1;
          mgmt_address   = ADDR_M;
          mgmt_writedata = div_word[1];
        end
        WR_C0: begin
          mgmt_write     = 1'b1;
          mgmt_address   = ADDR_C;
          mgmt_writedata = div_word[2];
        end
        WR_C1: begin
          mgmt_write     = 1'b1;
          mgmt_address   = ADDR_C;
          mgmt_writedata = div_word[3];
        end
        WR_START: begin
          mgmt_write     = 1'b1;
          mgmt_address   = ADDR_START;
          mgmt_writedata = 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_pll_reconfig_ctrl.sv
// Directed bench for kernel_pll_reconfig_ctrl: table of divide settings with
// hand-computed write words, plus stall, timeout, reset-abort and held-valid sequences.
module tb_kernel_pll_reconfig_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_m, cfg_n, cfg_c0, cfg_c1;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;
  logic        pll_locked;
  logic        busy, done, error;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] m, n, c0, c1;
    logic [31:0] exp_n, exp_m, exp_c0, exp_c1;
  } vec_t;
  vec_t vecs[3];

  always #10 clk = ~clk;

  kernel_pll_reconfig_ctrl #(
    .LOCK_STABLE_CYCLES  (16),
    .LOCK_TIMEOUT_CYCLES (100)
  ) dut (
    .refclk           (clk),
    .rst              (rst),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_m            (cfg_m),
    .cfg_n            (cfg_n),
    .cfg_c0           (cfg_c0),
    .cfg_c1           (cfg_c1),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_cfg(input int vi);
    cfg_m  = vecs[vi].m;
    cfg_n  = vecs[vi].n;
    cfg_c0 = vecs[vi].c0;
    cfg_c1 = vecs[vi].c1;
  endtask

  // Full sequence: accept, six writes (optional stall on write stall_k), lock, done.
  task automatic run_seq(input int vi, input int stall_k, input int stall_len);
    logic [5:0]  ea[6];
    logic [31:0] ed[6];
    int n;
    bit seen;
    ea = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h05, 6'h02};
    ed = '{32'h0, vecs[vi].exp_n, vecs[vi].exp_m, vecs[vi].exp_c0, vecs[vi].exp_c1, 32'h1};
    pll_locked = 1'b0;
    load_cfg(vi);
    cfg_valid = 1'b1;
    #1;
    check("accept_ready", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    #1;
    check("error_cleared", error, 0);
    check("busy_after_accept", busy, 1);
    for (int k = 0; k < 6; k++) begin
      if (k == stall_k) begin
        mgmt_waitrequest = 1'b1;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          check("stall_write", mgmt_write, 1);
          check("stall_addr", mgmt_address, ea[k]);
          check("stall_data", mgmt_writedata, ed[k]);
          tick();
        end
        mgmt_waitrequest = 1'b0;
      end
      #1;
      check("wr_strobe", mgmt_write, 1);
      check("wr_addr", mgmt_address, ea[k]);
      check("wr_data", mgmt_writedata, ed[k]);
      $display("vec %0d write %0d: addr 0x%0h data 0x%0h", vi, k, mgmt_address, mgmt_writedata);
      tick();
    end
    pll_locked = 1'b1;
    n = 1;
    seen = 1'b0;
    while (n <= 40 && !seen) begin
      #1;
      if (done) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check("done_seen", seen, 1);
    check("done_latency", n, 17);
    tick();
    #1;
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", cfg_ready, 1);
    $display("vec %0d sequence: done %0d cycles after START", vi, n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, accepts;
    bit seen, finished;

    vecs[0] = '{m: 16'h2020, n: 16'h0302, c0: 16'h0101, c1: 16'h0100,
                exp_n: 32'h20302, exp_m: 32'h02020, exp_c0: 32'h10101, exp_c1: 32'h60100};
    vecs[1] = '{m: 16'h0101, n: 16'h0001, c0: 16'h0504, c1: 16'h0303,
                exp_n: 32'h20001, exp_m: 32'h10101, exp_c0: 32'h20504, exp_c1: 32'h40303};
    vecs[2] = '{m: 16'h0000, n: 16'hFFFF, c0: 16'h0100, c1: 16'h0101,
                exp_n: 32'h0FFFF, exp_m: 32'h00000, exp_c0: 32'h20100, exp_c1: 32'h50101};

    rst = 1'b1;
    cfg_valid = 1'b0;
    mgmt_waitrequest = 1'b0;
    pll_locked = 1'b0;
    load_cfg(0);
    tick();
    tick();
    #1;
    check("rst_ready", cfg_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_write", mgmt_write, 0);
    check("rst_addr", mgmt_address, 0);
    check("rst_data", mgmt_writedata, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready", cfg_ready, 1);
    $display("reset: cfg_ready=%0d busy=%0d", cfg_ready, busy);

    for (int vi = 0; vi < 3; vi++) run_seq(vi, -1, 0);

    // Waitrequest held for 5 cycles on the M write.
    run_seq(0, 2, 5);

    // Lock toggling every 8 cycles never stays stable for 16: expect timeout.
    load_cfg(0);
    pll_locked = 1'b0;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    n = 1;
    seen = 1'b0;
    finished = 1'b0;
    while (n <= 200 && !finished) begin
      pll_locked = (((n - 1) / 8) % 2) == 0;
      #1;
      if (done) seen = 1'b1;
      if (!busy) finished = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check("timeout_reached", finished, 1);
    check("timeout_cycles", n, 101);
    check("timeout_no_done", seen, 0);
    check("timeout_error", error, 1);
    check("timeout_ready", cfg_ready, 1);
    $display("timeout: idle after %0d lock-wait cycles, error=%0d", n - 1, error);
    tick();
    tick();
    #1;
    check("error_sticky", error, 1);

    // Next request clears the error and completes.
    run_seq(1, -1, 0);

    // Reset during WR_C0 aborts with no further writes.
    load_cfg(1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    tick();
    #1;
    check("c0_addr_before_abort", mgmt_address, 6'h05);
    check("c0_data_before_abort", mgmt_writedata, vecs[1].exp_c0);
    rst = 1'b1;
    #1;
    check("abort_write_gated", mgmt_write, 0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_idle_busy", busy, 0);
    check("abort_idle_write", mgmt_write, 0);
    check("abort_idle_ready", cfg_ready, 1);
    $display("reset abort during WR_C0: busy=%0d write=%0d", busy, mgmt_write);
    run_seq(0, -1, 0);

    // cfg_valid held high: one accept per sequence.
    load_cfg(2);
    pll_locked = 1'b1;
    cfg_valid = 1'b1;
    n = 0;
    accepts = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      #1;
      if (cfg_ready) accepts++;
      if (done) seen = 1'b1;
      tick();
      n++;
    end
    check("held_done_seen", seen, 1);
    check("held_accepts", accepts, 1);
    check("held_cycles", n, 24);
    #1;
    check("held_reaccept_ready", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    #1;
    check("held_second_busy", busy, 1);
    $display("held valid: %0d accept(s) over %0d cycles", accepts, n);
    n = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      #1;
      if (done) seen = 1'b1;
      tick();
      n++;
    end
    check("held_second_done", seen, 1);
    #1;
    check("held_final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
